board_mem_arbiter: RTL and testbench
====================================

BOARD_MEM_ARBITER -- requirements
Module: board_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_COLS, default 7, meaning the number of board columns (memory words).
REQ-002 SHALL have parameter ROW_W, default 6, meaning the bits per column word.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  async active-low reset.
REQ-006 clear_req  in  1  single-cycle request to zero both boards.
REQ-007 clear_busy  out  1  high while the clear sequence runs.
REQ-008 clear_done  out  1  one-cycle pulse after the last column is cleared.
REQ-009 wr_req  in  1  game-FSM write request; held until wr_ack.
REQ-010 wr_addr  in  3  column to write.
REQ-011 wr_onoff, wr_player  in  ROW_W  write data.
REQ-012 wr_ack  out  1  one-cycle pulse in the cycle the write is issued.
REQ-013 lg_req / lg_addr  in  1 / 3  win-logic read request and column; held until lg_gnt.
REQ-014 lg_gnt, lg_valid  out  1 each  read grant; data valid one cycle later.
REQ-015 vga_req / vga_addr  in  1 / 3  display read request and column; held until vga_gnt.
REQ-016 vga_gnt, vga_valid  out  1 each  read grant; data valid one cycle later.
REQ-017 rd_onoff, rd_player  out  ROW_W  shared read data, qualified by lg_valid or vga_valid.
REQ-018 mem_addr  out  3  RAM address.
REQ-019 mem_we  out  1  RAM write enable, common to both boards.
REQ-020 mem_wd_onoff, mem_wd_player  out  ROW_W  RAM write data.
REQ-021 mem_rd_onoff, mem_rd_player  in  ROW_W  RAM read data; synchronous read, 1-cycle latency.

Function
REQ-022 SHALL implement states IDLE and CLEAR.
REQ-023 IDLE: in each cycle, SHALL grant at most one requester, in priority order clear_req > wr_req > lg_req > vga_req, subject to the anti-starvation rule.
REQ-024 A clear_req in IDLE SHALL move the block to CLEAR on the next edge and load clr_idx = 0; no grant or ack is issued in that cycle.
REQ-025 CLEAR: each cycle, mem_we=1, mem_addr=clr_idx, write data zero, clr_idx increments.
REQ-026 CLEAR: the cycle with clr_idx = NUM_COLS-1 SHALL be the last write; the block returns to IDLE, and clear_done pulses in the first IDLE cycle.
REQ-027 clear_busy SHALL be high for exactly NUM_COLS cycles.
REQ-028 clear_req SHALL be ignored while in CLEAR.
REQ-029 In CLEAR, wr_ack, lg_gnt and vga_gnt SHALL all be 0; pending requests wait.
REQ-030 Write grant: mem_we=1, mem_addr=wr_addr, data=wr_*, and wr_ack=1 in the same cycle.
REQ-031 Write with wr_addr >= NUM_COLS: wr_ack=1, mem_we=0.
REQ-032 Read grant: mem_we=0, mem_addr=req addr, and the matching gnt=1.
REQ-033 Read data: next cycle, the matching valid=1, with rd_* = mem_rd_*.
REQ-034 Out-of-range read: the grant is issued, and rd_* = 0 in the valid cycle.
REQ-035 A read grant issued in the cycle before CLEAR starts SHALL still deliver its valid cycle.
REQ-036 lg_valid and vga_valid SHALL never be high together.
REQ-037 Anti-starvation: a 2-bit counter SHALL increment each IDLE cycle in which vga_req=1 and vga is not granted.
REQ-038 The counter SHALL saturate at 3 and clear on any vga_gnt.
REQ-039 At count 3, vga SHALL rank above lg (still below clear and wr) for that cycle.
REQ-040 No grant SHALL be issued with no request; idle bus: mem_we=0, mem_addr=0, write data 0.

Reset
REQ-041 On reset low, the block SHALL immediately force: state IDLE; clr_idx, starvation counter and all outputs 0.
REQ-042 Reset mid-clear SHALL abort the sequence without restarting it; clear_done SHALL NOT pulse.
REQ-043 After reset release, the first edge SHALL service requests normally.

Verification
REQ-044 Scenario 1 -- clear_req pulse in IDLE. Required: clear_busy for 7 cycles; mem_we=1 with mem_addr 0..6 and zero data; clear_done one cycle after.
REQ-045 Scenario 2 -- wr_req (addr 3, onoff 6'h01, player 6'h01) together with lg_req. Required: wr_ack, mem_we=1, addr 3 first; lg_gnt next cycle; lg_valid the cycle after, with RAM data.
REQ-046 Scenario 3 -- lg_req held continuously with vga_req continuously. Required: vga_gnt within 4 cycles of vga_req rising; counter then clears.
REQ-047 Scenario 4 -- clear_req and wr_req (addr 2) in the same cycle. Required: 7 clear writes; wr_ack in the first IDLE cycle; column 2 then holds the new data.
REQ-048 Scenario 5 -- vga_req addr 7. Required: vga_gnt, then vga_valid with rd_*=0; wr_req addr 7 gives wr_ack with mem_we=0.
REQ-049 Scenario 6 -- reset asserted at clr_idx=3. Required: outputs 0 immediately; no clear_done; IDLE after release.

Source files
------------

// File: rtl/board_mem_arbiter.sv
// Shares one single-port board RAM (on/off plane + player plane) between a board clear
// sequencer, the game FSM writer, the win-logic reader and the VGA reader.
module board_mem_arbiter #(
    parameter int NUM_COLS = 7,
    parameter int ROW_W    = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_req_i,
    output logic             clear_busy_o,
    output logic             clear_done_o,
    input  logic             wr_req_i,
    input  logic [2:0]       wr_addr_i,
    input  logic [ROW_W-1:0] wr_onoff_i,
    input  logic [ROW_W-1:0] wr_player_i,
    output logic             wr_ack_o,
    input  logic             lg_req_i,
    input  logic [2:0]       lg_addr_i,
    output logic             lg_gnt_o,
    output logic             lg_valid_o,
    input  logic             vga_req_i,
    input  logic [2:0]       vga_addr_i,
    output logic             vga_gnt_o,
    output logic             vga_valid_o,
    output logic [ROW_W-1:0] rd_onoff_o,
    output logic [ROW_W-1:0] rd_player_o,
    output logic [2:0]       mem_addr_o,
    output logic             mem_we_o,
    output logic [ROW_W-1:0] mem_wd_onoff_o,
    output logic [ROW_W-1:0] mem_wd_player_o,
    input  logic [ROW_W-1:0] mem_rd_onoff_i,
    input  logic [ROW_W-1:0] mem_rd_player_i
);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] clr_idx_q, clr_idx_d;
    logic [1:0] starve_q, starve_d;
    logic       clear_done_q, clear_done_d;
    logic       lg_valid_q, lg_valid_d;
    logic       vga_valid_q, vga_valid_d;
    logic       rd_oor_q, rd_oor_d;
    logic       vga_first;

    function automatic logic in_range(input logic [2:0] addr);
        return int'({29'd0, addr}) < NUM_COLS;
    endfunction

    assign vga_first = (starve_q == 2'd3);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            clr_idx_q    <= 3'd0;
            starve_q     <= 2'd0;
            clear_done_q <= 1'b0;
            lg_valid_q   <= 1'b0;
            vga_valid_q  <= 1'b0;
            rd_oor_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            starve_q     <= starve_d;
            clear_done_q <= clear_done_d;
            lg_valid_q   <= lg_valid_d;
            vga_valid_q  <= vga_valid_d;
            rd_oor_q     <= rd_oor_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        clr_idx_d       = clr_idx_q;
        starve_d        = starve_q;
        clear_done_d    = 1'b0;
        lg_valid_d      = 1'b0;
        vga_valid_d     = 1'b0;
        rd_oor_d        = 1'b0;
        wr_ack_o        = 1'b0;
        lg_gnt_o        = 1'b0;
        vga_gnt_o       = 1'b0;
        mem_we_o        = 1'b0;
        mem_addr_o      = 3'd0;
        mem_wd_onoff_o  = '0;
        mem_wd_player_o = '0;

        // Combinational grants are held quiet while reset is asserted.
        if (rst_ni) begin
            if (state_q == ST_CLEAR) begin
                mem_we_o   = 1'b1;
                mem_addr_o = clr_idx_q;
                if (clr_idx_q == 3'(NUM_COLS - 1)) begin
                    state_d      = ST_IDLE;
                    clear_done_d = 1'b1;
                end else begin
                    clr_idx_d = clr_idx_q + 3'd1;
                end
            end else begin
                if (clear_req_i) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = 3'd0;
                end else if (wr_req_i) begin
                    wr_ack_o   = 1'b1;
                    mem_addr_o = wr_addr_i;
                    if (in_range(wr_addr_i)) begin
                        mem_we_o        = 1'b1;
                        mem_wd_onoff_o  = wr_onoff_i;
                        mem_wd_player_o = wr_player_i;
                    end
                end else if (lg_req_i && !(vga_req_i && vga_first)) begin
                    lg_gnt_o   = 1'b1;
                    mem_addr_o = lg_addr_i;
                    lg_valid_d = 1'b1;
                    rd_oor_d   = !in_range(lg_addr_i);
                end else if (vga_req_i) begin
                    vga_gnt_o   = 1'b1;
                    mem_addr_o  = vga_addr_i;
                    vga_valid_d = 1'b1;
                    rd_oor_d    = !in_range(vga_addr_i);
                end

                // A starved display request is promoted above win-logic once the count saturates.
                if (vga_gnt_o) begin
                    starve_d = 2'd0;
                end else if (vga_req_i && (starve_q != 2'd3)) begin
                    starve_d = starve_q + 2'd1;
                end
            end
        end
    end

    assign clear_busy_o = (state_q == ST_CLEAR);
    assign clear_done_o = clear_done_q;
    assign lg_valid_o   = lg_valid_q;
    assign vga_valid_o  = vga_valid_q;
    assign rd_onoff_o   = ((lg_valid_q || vga_valid_q) && !rd_oor_q) ? mem_rd_onoff_i  : '0;
    assign rd_player_o  = ((lg_valid_q || vga_valid_q) && !rd_oor_q) ? mem_rd_player_i : '0;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter: a vector table for single-cycle arbitration plus
// hand-written clear, starvation and mid-clear reset sequences against a small RAM model.
`timescale 1ns/1ps
module tb_board_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear_req, clear_busy, clear_done;
    logic       wr_req, wr_ack;
    logic [2:0] wr_addr;
    logic [5:0] wr_onoff, wr_player;
    logic       lg_req, lg_gnt, lg_valid;
    logic [2:0] lg_addr;
    logic       vga_req, vga_gnt, vga_valid;
    logic [2:0] vga_addr;
    logic [5:0] rd_onoff, rd_player;
    logic [2:0] mem_addr;
    logic       mem_we;
    logic [5:0] mem_wd_onoff, mem_wd_player;
    logic [5:0] mem_rd_onoff, mem_rd_player;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    board_mem_arbiter #(.NUM_COLS(7), .ROW_W(6)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .clear_req_i     (clear_req),
        .clear_busy_o    (clear_busy),
        .clear_done_o    (clear_done),
        .wr_req_i        (wr_req),
        .wr_addr_i       (wr_addr),
        .wr_onoff_i      (wr_onoff),
        .wr_player_i     (wr_player),
        .wr_ack_o        (wr_ack),
        .lg_req_i        (lg_req),
        .lg_addr_i       (lg_addr),
        .lg_gnt_o        (lg_gnt),
        .lg_valid_o      (lg_valid),
        .vga_req_i       (vga_req),
        .vga_addr_i      (vga_addr),
        .vga_gnt_o       (vga_gnt),
        .vga_valid_o     (vga_valid),
        .rd_onoff_o      (rd_onoff),
        .rd_player_o     (rd_player),
        .mem_addr_o      (mem_addr),
        .mem_we_o        (mem_we),
        .mem_wd_onoff_o  (mem_wd_onoff),
        .mem_wd_player_o (mem_wd_player),
        .mem_rd_onoff_i  (mem_rd_onoff),
        .mem_rd_player_i (mem_rd_player)
    );

    // Board RAM model: 8 words so an out-of-range column still returns nonzero raw data.
    logic [5:0] ram_on [8];
    logic [5:0] ram_pl [8];
    logic       ram_init = 1'b0;

    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 7; i++) begin
                ram_on[i] <= 6'h10 + 6'(i);
                ram_pl[i] <= 6'h20 + 6'(i);
            end
            ram_on[7] <= 6'h2d;
            ram_pl[7] <= 6'h1a;
            ram_init  <= 1'b1;
        end else if (mem_we) begin
            ram_on[mem_addr] <= mem_wd_onoff;
            ram_pl[mem_addr] <= mem_wd_player;
        end
        mem_rd_onoff  <= ram_on[mem_addr];
        mem_rd_player <= ram_pl[mem_addr];
    end

    typedef struct {
        logic       wr;
        logic [2:0] wa;
        logic [5:0] won;
        logic [5:0] wpl;
        logic       lg;
        logic [2:0] la;
        logic       vg;
        logic [2:0] va;
        logic [2:0] e_gnt;   // {wr_ack, lg_gnt, vga_gnt}
        logic       e_we;
        logic [2:0] e_addr;
        logic [5:0] e_wdo;
        logic [5:0] e_wdp;
        logic [1:0] e_val;   // {lg_valid, vga_valid} in the following cycle
        logic [5:0] e_rdo;
        logic [5:0] e_rdp;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        clear_req = 1'b0;
        wr_req    = 1'b0;
        wr_addr   = 3'd0;
        wr_onoff  = 6'h00;
        wr_player = 6'h00;
        lg_req    = 1'b0;
        lg_addr   = 3'd0;
        vga_req   = 1'b0;
        vga_addr  = 3'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit exp_v, prev_v;

        vecs[0]  = '{1'b0, 3'd0, 6'h00, 6'h00, 1'b0, 3'd0, 1'b0, 3'd0, 3'b000, 1'b0, 3'd0, 6'h00, 6'h00, 2'b00, 6'h00, 6'h00};
        vecs[1]  = '{1'b1, 3'd3, 6'h01, 6'h01, 1'b0, 3'd0, 1'b0, 3'd0, 3'b100, 1'b1, 3'd3, 6'h01, 6'h01, 2'b00, 6'h00, 6'h00};
        vecs[2]  = '{1'b0, 3'd0, 6'h00, 6'h00, 1'b1, 3'd3, 1'b0, 3'd0, 3'b010, 1'b0, 3'd3, 6'h00, 6'h00, 2'b10, 6'h01, 6'h01};
        vecs[3]  = '{1'b1, 3'd5, 6'h2a, 6'h15, 1'b1, 3'd1, 1'b0, 3'd0, 3'b100, 1'b1, 3'd5, 6'h2a, 6'h15, 2'b00, 6'h00, 6'h00};
        vecs[4]  = '{1'b0, 3'd0, 6'h00, 6'h00, 1'b0, 3'd0, 1'b1, 3'd5, 3'b001, 1'b0, 3'd5, 6'h00, 6'h00, 2'b01, 6'h2a, 6'h15};
        vecs[5]  = '{1'b0, 3'd0, 6'h00, 6'h00, 1'b1, 3'd0, 1'b0, 3'd0, 3'b010, 1'b0, 3'd0, 6'h00, 6'h00, 2'b10, 6'h10, 6'h20};
        vecs[6]  = '{1'b1, 3'd7, 6'h3f, 6'h3f, 1'b0, 3'd0, 1'b0, 3'd0, 3'b100, 1'b0, 3'd7, 6'h00, 6'h00, 2'b00, 6'h00, 6'h00};
        vecs[7]  = '{1'b0, 3'd0, 6'h00, 6'h00, 1'b0, 3'd0, 1'b1, 3'd7, 3'b001, 1'b0, 3'd7, 6'h00, 6'h00, 2'b01, 6'h00, 6'h00};
        vecs[8]  = '{1'b0, 3'd0, 6'h00, 6'h00, 1'b1, 3'd6, 1'b0, 3'd0, 3'b010, 1'b0, 3'd6, 6'h00, 6'h00, 2'b10, 6'h16, 6'h26};
        vecs[9]  = '{1'b1, 3'd6, 6'h00, 6'h3f, 1'b1, 3'd2, 1'b0, 3'd0, 3'b100, 1'b1, 3'd6, 6'h00, 6'h3f, 2'b00, 6'h00, 6'h00};
        vecs[10] = '{1'b0, 3'd0, 6'h00, 6'h00, 1'b1, 3'd6, 1'b0, 3'd0, 3'b010, 1'b0, 3'd6, 6'h00, 6'h00, 2'b10, 6'h00, 6'h3f};
        vecs[11] = '{1'b0, 3'd0, 6'h00, 6'h00, 1'b1, 3'd7, 1'b0, 3'd0, 3'b010, 1'b0, 3'd7, 6'h00, 6'h00, 2'b10, 6'h00, 6'h00};

        // Reset held with every requester active: all outputs stay zero.
        rst_n = 1'b0;
        idle_inputs();
        wr_req   = 1'b1;
        wr_addr  = 3'd3;
        wr_onoff = 6'h3f;
        lg_req   = 1'b1;
        vga_req  = 1'b1;
        vga_addr = 3'd2;
        repeat (2) @(posedge clk);
        #5;
        chk("reset grants", {29'd0, wr_ack, lg_gnt, vga_gnt}, 32'd0);
        chk("reset bus", {mem_we, mem_addr, mem_wd_onoff, mem_wd_player}, 32'd0);
        chk("reset status", {clear_busy, clear_done, lg_valid, vga_valid}, 32'd0);
        chk("reset rd", {rd_onoff, rd_player}, 32'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        rst_n = 1'b1;
        next_cycle();

        // Single-cycle arbitration vectors, each followed by an idle cycle for the read data.
        for (int i = 0; i < 12; i++) begin
            wr_req    = vecs[i].wr;
            wr_addr   = vecs[i].wa;
            wr_onoff  = vecs[i].won;
            wr_player = vecs[i].wpl;
            lg_req    = vecs[i].lg;
            lg_addr   = vecs[i].la;
            vga_req   = vecs[i].vg;
            vga_addr  = vecs[i].va;
            #4;
            chk($sformatf("vec%0d grants", i), {29'd0, wr_ack, lg_gnt, vga_gnt}, {29'd0, vecs[i].e_gnt});
            chk($sformatf("vec%0d we/addr", i), {28'd0, mem_we, mem_addr}, {28'd0, vecs[i].e_we, vecs[i].e_addr});
            chk($sformatf("vec%0d wdata", i), {20'd0, mem_wd_onoff, mem_wd_player}, {20'd0, vecs[i].e_wdo, vecs[i].e_wdp});
            $display("vec%0d: wr=%0b lg=%0b vga=%0b -> ack=%0b lg_gnt=%0b vga_gnt=%0b we=%0b addr=%0d",
                     i, vecs[i].wr, vecs[i].lg, vecs[i].vg, wr_ack, lg_gnt, vga_gnt, mem_we, mem_addr);
            next_cycle();
            idle_inputs();
            #4;
            chk($sformatf("vec%0d valids", i), {30'd0, lg_valid, vga_valid}, {30'd0, vecs[i].e_val});
            if (vecs[i].e_val != 2'b00) begin
                chk($sformatf("vec%0d rdata", i), {20'd0, rd_onoff, rd_player}, {20'd0, vecs[i].e_rdo, vecs[i].e_rdp});
            end
            next_cycle();
        end

        // Clear requested together with a write to column 2; a mid-clear clear_req is ignored.
        clear_req = 1'b1;
        wr_req    = 1'b1;
        wr_addr   = 3'd2;
        wr_onoff  = 6'h15;
        wr_player = 6'h2a;
        #4;
        chk("clr start cycle", {29'd0, wr_ack, mem_we, clear_busy}, 32'd0);
        next_cycle();
        clear_req = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i == 2) clear_req = 1'b1;
            if (i == 3) clear_req = 1'b0;
            #4;
            chk($sformatf("clr%0d busy", i), {31'd0, clear_busy}, 32'd1);
            chk($sformatf("clr%0d we/addr", i), {28'd0, mem_we, mem_addr}, {28'd0, 1'b1, 3'(i)});
            chk($sformatf("clr%0d wdata", i), {20'd0, mem_wd_onoff, mem_wd_player}, 32'd0);
            chk($sformatf("clr%0d ack/done", i), {30'd0, wr_ack, clear_done}, 32'd0);
            $display("clear cycle %0d: busy=%0b we=%0b addr=%0d", i, clear_busy, mem_we, mem_addr);
            next_cycle();
        end
        #4;
        chk("clr end busy/done", {30'd0, clear_busy, clear_done}, 32'd1);
        chk("clr pending write", {27'd0, wr_ack, mem_we, mem_addr}, {27'd0, 1'b1, 1'b1, 3'd2});
        chk("clr pending wdata", {20'd0, mem_wd_onoff, mem_wd_player}, {20'd0, 6'h15, 6'h2a});
        next_cycle();
        wr_req  = 1'b0;
        lg_req  = 1'b1;
        lg_addr = 3'd2;
        #4;
        chk("clr done pulse width", {31'd0, clear_done}, 32'd0);
        chk("clr rd col2 gnt", {31'd0, lg_gnt}, 32'd1);
        next_cycle();
        lg_addr = 3'd4;
        #4;
        chk("clr col2 data", {19'd0, lg_valid, rd_onoff, rd_player}, {19'd0, 1'b1, 6'h15, 6'h2a});
        next_cycle();
        idle_inputs();
        #4;
        chk("clr col4 zeroed", {19'd0, lg_valid, rd_onoff, rd_player}, {19'd0, 1'b1, 6'h00, 6'h00});
        $display("clear sequence: col2=%0h/%0h after clear+write", 6'h15, 6'h2a);
        next_cycle();

        // Win-logic and display both requesting continuously: display wins every 4th cycle.
        lg_req   = 1'b1;
        lg_addr  = 3'd1;
        vga_req  = 1'b1;
        vga_addr = 3'd4;
        prev_v   = 1'b0;
        for (int c = 0; c < 8; c++) begin
            exp_v = ((c % 4) == 3);
            #4;
            chk($sformatf("starve%0d gnt", c), {30'd0, lg_gnt, vga_gnt}, {30'd0, !exp_v, exp_v});
            chk($sformatf("starve%0d addr", c), {29'd0, mem_addr}, exp_v ? 32'd4 : 32'd1);
            chk($sformatf("starve%0d valid excl", c), {31'd0, lg_valid & vga_valid}, 32'd0);
            if (c > 0) begin
                chk($sformatf("starve%0d valids", c), {30'd0, lg_valid, vga_valid}, {30'd0, !prev_v, prev_v});
            end
            $display("starve cycle %0d: lg_gnt=%0b vga_gnt=%0b", c, lg_gnt, vga_gnt);
            prev_v = exp_v;
            next_cycle();
        end
        idle_inputs();
        #4;
        chk("starve last valid", {30'd0, lg_valid, vga_valid}, 32'd1);
        chk("starve vga rdata", {20'd0, rd_onoff, rd_player}, {20'd0, 6'h00, 6'h00});
        next_cycle();

        // Reset asserted while column 3 is being cleared.
        clear_req = 1'b1;
        #4;
        next_cycle();
        clear_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #4;
            chk($sformatf("abort clr%0d addr", i), {28'd0, mem_we, mem_addr}, {28'd0, 1'b1, 3'(i)});
            if (i < 3) next_cycle();
        end
        wr_req    = 1'b1;
        wr_addr   = 3'd1;
        wr_onoff  = 6'h07;
        wr_player = 6'h03;
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort busy/done", {30'd0, clear_busy, clear_done}, 32'd0);
        chk("abort bus", {mem_we, mem_addr, mem_wd_onoff, mem_wd_player}, 32'd0);
        chk("abort ack", {31'd0, wr_ack}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #4;
        chk("post reset write", {27'd0, wr_ack, mem_we, mem_addr}, {27'd0, 1'b1, 1'b1, 3'd1});
        chk("post reset idle", {30'd0, clear_busy, clear_done}, 32'd0);
        $display("reset mid-clear: busy=%0b done=%0b ack=%0b", clear_busy, clear_done, wr_ack);
        next_cycle();
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            #4;
            chk($sformatf("no done %0d", i), {30'd0, clear_busy, clear_done}, 32'd0);
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
